exec_unit_p: RTL
================

Name: exec_unit_p

Overview:
- Parametrised successor to the 16-bit single-cycle processor datapath.
- Generalised in data width and register count.
- Adds a valid/ready instruction handshake, an iterative multi-cycle multiplier with stall, a registered flag set, external load/store opcodes, an illegal-opcode error pulse and a debug read port.
- Sits between the instruction fetch/sequencer and the I/O interface.

Parameters:
- DATA_W, 16, datapath, GPR and SGPR width (8..32).
- NREG, 32, number of GPRs (2..32); register index fields are always 5 bits, indices >= NREG read 0 and writes to them are dropped.
- MUL_ITER, 1, 1 = shift-add multiplier taking DATA_W cycles; 0 = single-cycle multiply.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- instr  in  32  instruction word.
- instr_valid  in  1  instr is valid this cycle.
- instr_ready  out  1  unit can accept an instruction.
- din  in  DATA_W  external data for LDIN.
- dout  out  DATA_W  last GPR write value or STOUT value.
- dout_valid  out  1  one-cycle pulse when dout updates.
- zero, sign, carry, overflow  out  1 each  registered flags.
- err  out  1  one-cycle pulse on illegal opcode.
- dbg_addr  in  5  debug register select (31 selects SGPR when NREG<32; otherwise GPR31).
- dbg_data  out  DATA_W  combinational read of the selected register.

Behaviour:
- Field layout:
  - oper_type [31:27], rdst [26:22], rsrc1 [21:17], imm_mode [16], rsrc2 [15:11], isrc [15:0].
  - op2 = imm_mode ? zero-extended or truncated isrc : GPR[rsrc2].
- Opcodes:
  - 0 MOVSGPR: rdst = SGPR.
  - 1 MOV: rdst = op2 if imm_mode, else rsrc1.
  - 2 ADD, 3 SUB.
  - 4 MUL: {SGPR, rdst} = rsrc1 * op2, unsigned, 2*DATA_W bits.
  - 5 OR, 6 AND, 7 XOR, 8 XNOR, 9 NAND, 10 NOR.
  - 11 NOT: rdst = ~rsrc1.
  - 12 LDIN: rdst = din, sampled in the accept cycle.
  - 13 STOUT: dout = rsrc1, no GPR write.
  - 14..31 illegal.
- Handshake:
  - An instruction is accepted when instr_valid && instr_ready at a rising edge.
  - instr may change freely while instr_ready is 0.
- Latency:
  - Non-MUL ops (and MUL with MUL_ITER=0): GPR, flags and dout update at the accepting edge; instr_ready stays 1, giving back-to-back throughput of 1 per cycle.
  - MUL with MUL_ITER=1: the accepting edge latches operands, rdst and a counter = DATA_W; the FSM goes IDLE -> MUL and instr_ready = 0. Each cycle performs one shift-add step. On the edge where the counter reaches 0, rdst, SGPR, flags and dout are written, dout_valid pulses, and the FSM returns to IDLE (instr_ready = 1 on the following cycle). Total DATA_W cycles of stall.
- Flags, updated on every GPR-writing op:
  - zero = (result == 0); for MUL, zero = full 2*DATA_W product == 0.
  - sign = result MSB; for MUL, the SGPR MSB.
  - carry and overflow are updated only by ADD/SUB, otherwise held:
    - ADD: carry = bit DATA_W of the sum; overflow = operands share a sign and the result sign differs.
    - SUB: carry = borrow (rsrc1 < op2 unsigned); overflow = operands differ in sign and the result sign differs from rsrc1.
  - MOVSGPR, STOUT, illegal ops and NOPs leave all flags unchanged.
- Outputs:
  - dout and dout_valid follow every GPR write and every STOUT.
  - An illegal opcode pulses err for one cycle and changes no other state.
- Hazards:
  - A read of a register written in the previous cycle sees the new value; the write is complete before the next accept.
  - rdst == rsrc1 is legal.
- Reset (asserted at any time, including mid-MUL):
  - Immediately: all GPRs and SGPR = 0, flags = 0, dout = 0, dout_valid = 0, err = 0, FSM = IDLE, counter = 0, instr_ready = 1.
  - An in-flight MUL is discarded.
  - After deassertion, the first accept is possible at the next rising edge.

Test Plan:
- After reset: MOV imm r2 = 5, then ADD imm r0 = r2 + 5 → r0 = 10, zero = 0, sign = 0, dout = 10, dout_valid pulses once per instruction, instr_ready stays 1.
- MOV imm r4 = 0x0102, MOV imm r5 = 0x0300, MUL r1 = r4 * r5 (MUL_ITER = 1) → instr_ready low for exactly 16 cycles, r1 = 0x0600, SGPR = 0x0003, MOVSGPR r3 → r3 = 0x0003.
- r0 = 0x8002, r1 = 0x8000, ADD r2 = r0 + r1 → r2 = 0x0002, carry = 1, overflow = 1, sign = 0; then SUB r3 = r1 - r1 → r3 = 0, zero = 1, carry = 0, overflow = 0.
- din = 0xBEEF, LDIN r7, then STOUT r7 → r7 = 0xBEEF, dout = 0xBEEF, sign = 1; a following AND imm r8 = r7 & 9 → r8 = 0x0009.
- opcode 20 with instr_valid → err pulses for one cycle; GPRs, flags and dout are unchanged; NOT on r8 = 0 → 0xFFFF.
- Assert reset 5 cycles into a MUL → instr_ready = 1, all registers and flags 0 immediately, no dout_valid pulse; the next ADD executes normally.
- Repeat the plan with DATA_W = 8, NREG = 8, MUL_ITER = 0: MUL completes in 1 cycle, and writes to r9 are dropped (r9 reads 0).

Source files
------------

// File: rtl/exec_unit_p.sv
// Parametrised execution unit: GPR file, SGPR, ALU, optional iterative multiplier,
// valid/ready instruction handshake, registered flags and a debug read port.
module exec_unit_p #(
  parameter int DATA_W   = 16,
  parameter int NREG     = 32,
  parameter int MUL_ITER = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              zero,
  output logic              sign,
  output logic              carry,
  output logic              overflow,
  output logic              err,
  input  logic [4:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int W  = DATA_W;
  localparam int PW = 2 * DATA_W;

  localparam logic [4:0] OP_MOVSGPR = 5'd0;
  localparam logic [4:0] OP_MOV     = 5'd1;
  localparam logic [4:0] OP_ADD     = 5'd2;
  localparam logic [4:0] OP_SUB     = 5'd3;
  localparam logic [4:0] OP_MUL     = 5'd4;
  localparam logic [4:0] OP_OR      = 5'd5;
  localparam logic [4:0] OP_AND     = 5'd6;
  localparam logic [4:0] OP_XOR     = 5'd7;
  localparam logic [4:0] OP_XNOR    = 5'd8;
  localparam logic [4:0] OP_NAND    = 5'd9;
  localparam logic [4:0] OP_NOR     = 5'd10;
  localparam logic [4:0] OP_NOT     = 5'd11;
  localparam logic [4:0] OP_LDIN    = 5'd12;
  localparam logic [4:0] OP_STOUT   = 5'd13;

  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t        state_reg, state_next;
  logic [5:0]    cnt_reg, cnt_next;
  logic [W-1:0]  mcand_reg, mcand_next;
  logic [PW-1:0] acc_reg, acc_next;
  logic [4:0]    mdst_reg, mdst_next;
  logic [W-1:0]  sgpr_reg, dout_reg;
  logic          dout_valid_reg, err_reg;
  logic          zero_reg, sign_reg, carry_reg, ovf_reg;

  logic [W-1:0]  rf [32];

  logic [4:0]    opc, rdst, rsrc1, rsrc2;
  logic          imm_mode, accept;
  logic [15:0]   isrc;
  logic [W-1:0]  src1, op2;
  logic [W:0]    add_sum, sub_diff, step_sum;
  logic [PW-1:0] prod_full, step_acc;

  logic          gpr_we, sgpr_we, set_zs, set_cv, dout_we, err_pulse, mul_wr;
  logic [4:0]    wr_idx, mul_dst;
  logic [W-1:0]  wr_data, sgpr_data, dout_data;
  logic          zero_new, sign_new, carry_new, ovf_new;
  logic [PW-1:0] mul_res;

  assign opc      = instr[31:27];
  assign rdst     = instr[26:22];
  assign rsrc1    = instr[21:17];
  assign imm_mode = instr[16];
  assign rsrc2    = instr[15:11];
  assign isrc     = instr[15:0];

  assign src1 = rf[rsrc1];
  assign op2  = imm_mode ? W'(isrc) : rf[rsrc2];

  assign instr_ready = (state_reg == S_IDLE);
  assign accept      = instr_valid && instr_ready;

  assign add_sum   = {1'b0, src1} + {1'b0, op2};
  assign sub_diff  = {1'b0, src1} - {1'b0, op2};
  assign prod_full = {{W{1'b0}}, src1} * {{W{1'b0}}, op2};

  // Shift-add step: upper half accumulates the multiplicand, low half holds the remaining multiplier bits.
  assign step_sum = {1'b0, acc_reg[PW-1:W]} + (acc_reg[0] ? {1'b0, mcand_reg} : {(W+1){1'b0}});
  assign step_acc = {step_sum, acc_reg[W-1:1]};

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    mcand_next = mcand_reg;
    acc_next   = acc_reg;
    mdst_next  = mdst_reg;
    gpr_we     = 1'b0;
    wr_idx     = rdst;
    wr_data    = '0;
    sgpr_we    = 1'b0;
    sgpr_data  = '0;
    set_zs     = 1'b0;
    zero_new   = 1'b0;
    sign_new   = 1'b0;
    set_cv     = 1'b0;
    carry_new  = 1'b0;
    ovf_new    = 1'b0;
    dout_we    = 1'b0;
    dout_data  = '0;
    err_pulse  = 1'b0;
    mul_wr     = 1'b0;
    mul_res    = '0;
    mul_dst    = rdst;

    if (state_reg == S_MUL) begin
      acc_next = step_acc;
      cnt_next = cnt_reg - 6'd1;
      if (cnt_reg == 6'd1) begin
        mul_wr     = 1'b1;
        mul_res    = step_acc;
        mul_dst    = mdst_reg;
        state_next = S_IDLE;
      end
    end else if (accept) begin
      case (opc)
        OP_MOVSGPR: begin gpr_we = 1'b1; wr_data = sgpr_reg; end
        OP_MOV:     begin gpr_we = 1'b1; set_zs = 1'b1; wr_data = imm_mode ? op2 : src1; end
        OP_ADD: begin
          gpr_we    = 1'b1;
          set_zs    = 1'b1;
          set_cv    = 1'b1;
          wr_data   = add_sum[W-1:0];
          carry_new = add_sum[W];
          ovf_new   = (src1[W-1] == op2[W-1]) && (add_sum[W-1] != src1[W-1]);
        end
        OP_SUB: begin
          gpr_we    = 1'b1;
          set_zs    = 1'b1;
          set_cv    = 1'b1;
          wr_data   = sub_diff[W-1:0];
          carry_new = sub_diff[W];
          ovf_new   = (src1[W-1] != op2[W-1]) && (sub_diff[W-1] != src1[W-1]);
        end
        OP_MUL: begin
          if (MUL_ITER != 0) begin
            state_next = S_MUL;
            cnt_next   = 6'(W);
            mcand_next = src1;
            acc_next   = {{W{1'b0}}, op2};
            mdst_next  = rdst;
          end else begin
            mul_wr  = 1'b1;
            mul_res = prod_full;
          end
        end
        OP_OR:    begin gpr_we = 1'b1; set_zs = 1'b1; wr_data = src1 | op2; end
        OP_AND:   begin gpr_we = 1'b1; set_zs = 1'b1; wr_data = src1 & op2; end
        OP_XOR:   begin gpr_we = 1'b1; set_zs = 1'b1; wr_data = src1 ^ op2; end
        OP_XNOR:  begin gpr_we = 1'b1; set_zs = 1'b1; wr_data = ~(src1 ^ op2); end
        OP_NAND:  begin gpr_we = 1'b1; set_zs = 1'b1; wr_data = ~(src1 & op2); end
        OP_NOR:   begin gpr_we = 1'b1; set_zs = 1'b1; wr_data = ~(src1 | op2); end
        OP_NOT:   begin gpr_we = 1'b1; set_zs = 1'b1; wr_data = ~src1; end
        OP_LDIN:  begin gpr_we = 1'b1; set_zs = 1'b1; wr_data = din; end
        OP_STOUT: begin dout_we = 1'b1; dout_data = src1; end
        default:  err_pulse = 1'b1;
      endcase
    end

    if (set_zs) begin
      zero_new = (wr_data == '0);
      sign_new = wr_data[W-1];
    end

    // MUL flags look at the whole product; sign comes from the SGPR half.
    if (mul_wr) begin
      gpr_we    = 1'b1;
      wr_idx    = mul_dst;
      wr_data   = mul_res[W-1:0];
      sgpr_we   = 1'b1;
      sgpr_data = mul_res[PW-1:W];
      set_zs    = 1'b1;
      zero_new  = (mul_res == '0);
      sign_new  = mul_res[PW-1];
    end

    if (gpr_we) begin
      dout_we   = 1'b1;
      dout_data = wr_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg      <= S_IDLE;
      cnt_reg        <= '0;
      mcand_reg      <= '0;
      acc_reg        <= '0;
      mdst_reg       <= '0;
      sgpr_reg       <= '0;
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
      err_reg        <= 1'b0;
      zero_reg       <= 1'b0;
      sign_reg       <= 1'b0;
      carry_reg      <= 1'b0;
      ovf_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      mcand_reg      <= mcand_next;
      acc_reg        <= acc_next;
      mdst_reg       <= mdst_next;
      dout_valid_reg <= dout_we;
      err_reg        <= err_pulse;
      if (sgpr_we) sgpr_reg <= sgpr_data;
      if (dout_we) dout_reg <= dout_data;
      if (set_zs) begin
        zero_reg <= zero_new;
        sign_reg <= sign_new;
      end
      if (set_cv) begin
        carry_reg <= carry_new;
        ovf_reg   <= ovf_new;
      end
    end
  end

  // Indices at or above NREG have no storage: they read as zero and swallow writes.
  for (genvar gi = 0; gi < 32; gi++) begin : g_rf
    if (gi < NREG) begin : g_reg
      logic [W-1:0] q_reg;
      always_ff @(posedge clock or negedge reset) begin
        if (!reset)                              q_reg <= '0;
        else if (gpr_we && (wr_idx == 5'(gi)))   q_reg <= wr_data;
      end
      assign rf[gi] = q_reg;
    end else begin : g_none
      assign rf[gi] = '0;
    end
  end

  assign dbg_data   = (NREG < 32 && dbg_addr == 5'd31) ? sgpr_reg : rf[dbg_addr];
  assign dout       = dout_reg;
  assign dout_valid = dout_valid_reg;
  assign err        = err_reg;
  assign zero       = zero_reg;
  assign sign       = sign_reg;
  assign carry      = carry_reg;
  assign overflow   = ovf_reg;

endmodule
